// File: rtl/hazard_defs.sv
// hazard_defs: constants shared by the hazard unit and its scoreboard bank.
package hazard_defs;

  // Default register index width (32 architectural registers).
  localparam int AW_DEF = 5;

  // E-stage forwarding mux selects.
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/hazard_sb_bank.sv
// hazard_sb_bank: one pending bit per register for long-latency writers.
// Set on issue, cleared on out-of-band completion, wiped by flush.
// Three lookup ports let the D stage check rs, rt and its destination at once.
module hazard_sb_bank
  import hazard_defs::*;
#(
  parameter int AW = AW_DEF,
  localparam int NREG = 1 << AW,
  localparam int CW = $clog2(NREG + 1)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                set_valid,
  input  logic [AW-1:0]       set_reg,
  input  logic                clr_valid,
  input  logic [AW-1:0]       clr_reg,
  input  logic                flush,
  input  logic [2:0][AW-1:0]  rd_idx,
  output logic [2:0]          rd_pend,
  output logic [CW-1:0]       pend_cnt
);

  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_next;
  logic [CW-1:0]   cnt_next;
  logic            do_set;
  logic            do_clr;

  // Qualify set/clear; a set to the register completing this cycle is a new writer.
  always_comb begin
    do_clr = clr_valid && (clr_reg != '0) && pend[clr_reg] && !flush;
    do_set = set_valid && (set_reg != '0) && !flush &&
             (!pend[set_reg] || (do_clr && (clr_reg == set_reg)));
  end

  // Next pending vector and count: clear first so a same-register set wins.
  always_comb begin
    pend_next = pend;
    cnt_next  = pend_cnt;
    if (flush) begin
      pend_next = '0;
      cnt_next  = '0;
    end else begin
      if (do_clr) pend_next[clr_reg] = 1'b0;
      if (do_set) pend_next[set_reg] = 1'b1;
      cnt_next = pend_cnt + CW'(do_set) - CW'(do_clr);
    end
  end

  // Pending state and its population count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= pend_next;
      pend_cnt <= cnt_next;
    end
  end

  // Lookup ports; register 0 is never set so it always reads clear.
  for (genvar gi = 0; gi < 3; gi++) begin : g_rd
    assign rd_pend[gi] = pend[rd_idx[gi]];
  end

  // Issue to a still-pending register, or completion of a non-pending one, is illegal.
  always @(posedge clk) begin
    if (resetn && !flush) begin
      assert (!(set_valid && set_reg != '0 && pend[set_reg] &&
                !(clr_valid && clr_reg == set_reg)));
      assert (!(clr_valid && clr_reg != '0 && !pend[clr_reg]));
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: forwarding selects, load-use/branch/scoreboard stalls
// and exception flush for the 5-stage core.
// Optional HAZARD_PERF_EN adds saturating stall/flush perf counters.
module hazard_scoreboard
  import hazard_defs::*;
#(
  parameter int AW = AW_DEF
`ifdef HAZARD_PERF_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [AW-1:0]               rsD,
  input  logic [AW-1:0]               rtD,
  input  logic [AW-1:0]               writeregD,
  input  logic                        regwriteD,
  input  logic                        branchD,
  input  logic [AW-1:0]               rsE,
  input  logic [AW-1:0]               rtE,
  input  logic [AW-1:0]               writeregE,
  input  logic                        regwriteE,
  input  logic                        memtoregE,
  input  logic                        longE,
  input  logic [AW-1:0]               writeregM,
  input  logic                        regwriteM,
  input  logic                        memtoregM,
  input  logic [AW-1:0]               writeregW,
  input  logic                        regwriteW,
  input  logic                        cplt_valid,
  input  logic [AW-1:0]               cplt_reg,
  input  logic                        flush_i,
  output logic                        forwardaD,
  output logic                        forwardbD,
  output logic [1:0]                  forwardaE,
  output logic [1:0]                  forwardbE,
  output logic                        stallF,
  output logic                        stallD,
  output logic                        stallE,
  output logic                        flushD,
  output logic                        flushE,
  output logic                        flushM,
  output logic [$clog2((1<<AW)+1)-1:0] pend_cnt
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]            stall_cyc,
  output logic [CNT_W-1:0]            flush_cnt
`endif
);

  logic [2:0] rd_pend;
  logic       issue;
  logic       lwstall;
  logic       brstall;
  logic       sbstall;
  logic       stall_any;

  assign issue = longE && regwriteE && (writeregE != '0) && !flush_i;

  hazard_sb_bank #(.AW(AW)) u_bank (
    .clk       (clk),
    .resetn    (resetn),
    .set_valid (issue),
    .set_reg   (writeregE),
    .clr_valid (cplt_valid),
    .clr_reg   (cplt_reg),
    .flush     (flush_i),
    .rd_idx    ({writeregD, rtD, rsD}),
    .rd_pend   (rd_pend),
    .pend_cnt  (pend_cnt)
  );

  // Forwarding: M beats W, never forward register 0; D-stage forwards from M only.
  always_comb begin
    forwardaE = FWD_REG;
    forwardbE = FWD_REG;
    if (rsE != '0 && regwriteM && writeregM == rsE)      forwardaE = FWD_M;
    else if (rsE != '0 && regwriteW && writeregW == rsE) forwardaE = FWD_W;
    if (rtE != '0 && regwriteM && writeregM == rtE)      forwardbE = FWD_M;
    else if (rtE != '0 && regwriteW && writeregW == rtE) forwardbE = FWD_W;
    forwardaD = (rsD != '0) && regwriteM && (writeregM == rsD);
    forwardbD = (rtD != '0) && regwriteM && (writeregM == rtD);
  end

  // Stall sources; flush overrides stall so the faulting bubble drains.
  always_comb begin
    lwstall = memtoregE && (rtE != '0) && (rtE == rsD || rtE == rtD);
    brstall = branchD &&
              ((regwriteE && writeregE != '0 && (writeregE == rsD || writeregE == rtD)) ||
               (memtoregM && writeregM != '0 && (writeregM == rsD || writeregM == rtD)));
    sbstall = rd_pend[0] || rd_pend[1] || (regwriteD && rd_pend[2]);
    stall_any = (lwstall || brstall || sbstall) && !flush_i;
    stallF = stall_any;
    stallD = stall_any;
    stallE = stall_any;
    flushE = stall_any || flush_i;
    flushD = flush_i;
    flushM = flush_i;
  end

`ifdef HAZARD_PERF_EN
  // Saturating perf counters for stalled and flushed cycles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cyc <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_any && stall_cyc != '1) stall_cyc <= stall_cyc + CNT_W'(1);
      if (flush_i && flush_cnt != '1)   flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus randomized traffic against a
// set-of-pending-registers reference model; a monitor pops expectations per cycle.
`timescale 1ns/1ps
module tb_hazard_scoreboard;

  localparam int AW = 5;
  localparam int CW = 6;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [AW-1:0] rsD, rtD, writeregD, rsE, rtE, writeregE, writeregM, writeregW, cplt_reg;
  logic regwriteD, branchD, regwriteE, memtoregE, longE, regwriteM, memtoregM, regwriteW;
  logic cplt_valid, flush_i;
  logic forwardaD, forwardbD, stallF, stallD, stallE, flushD, flushE, flushM;
  logic [1:0] forwardaE, forwardbE;
  logic [CW-1:0] pend_cnt;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cyc, flush_cnt;
`endif

  hazard_scoreboard dut (
    .clk(clk), .resetn(resetn),
    .rsD(rsD), .rtD(rtD), .writeregD(writeregD), .regwriteD(regwriteD), .branchD(branchD),
    .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE),
    .memtoregE(memtoregE), .longE(longE),
    .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
    .writeregW(writeregW), .regwriteW(regwriteW),
    .cplt_valid(cplt_valid), .cplt_reg(cplt_reg), .flush_i(flush_i),
    .forwardaD(forwardaD), .forwardbD(forwardbD), .forwardaE(forwardaE), .forwardbE(forwardbE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .pend_cnt(pend_cnt)
`ifdef HAZARD_PERF_EN
    , .stall_cyc(stall_cyc), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int fad, fbd, fae, fbe;
    int stall, fd, fe, fm;
    int cnt, sc, fc;
  } exp_t;

  exp_t q[$];
  bit   mpend [32];
  int   m_stall_cyc = 0;
  int   m_flush_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;

  task automatic chk(input string nm, input int id, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s txn %0d: got %0d expected %0d", nm, id, act, exp);
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(mpend[i]);
    return n;
  endfunction

  // Forward select for an E source: M has priority over W, r0 never forwarded.
  function automatic int fwd_e(input logic [AW-1:0] src);
    if (src == 0) return 0;
    if (regwriteM && writeregM == src) return 2;
    if (regwriteW && writeregW == src) return 1;
    return 0;
  endfunction

  function automatic int uses(input logic [AW-1:0] r);
    return int'(r != 0 && (r == rsD || r == rtD));
  endfunction

  task automatic clear_inputs();
    {rsD, rtD, writeregD, rsE, rtE, writeregE, writeregM, writeregW, cplt_reg} = '0;
    {regwriteD, branchD, regwriteE, memtoregE, longE, regwriteM, memtoregM, regwriteW} = '0;
    cplt_valid = 1'b0;
    flush_i = 1'b0;
  endtask

  // One cycle: predict outputs for the current inputs, then advance the model at the edge.
  task automatic step();
    exp_t e;
    int lw, br, sb;
    lw = int'(memtoregE && rtE != 0 && (rtE == rsD || rtE == rtD));
    br = int'(branchD && ((regwriteE && uses(writeregE) != 0) ||
                          (memtoregM && uses(writeregM) != 0)));
    sb = int'(mpend[rsD] || mpend[rtD] || (regwriteD && mpend[writeregD]));
    e.id    = txn++;
    e.fae   = fwd_e(rsE);
    e.fbe   = fwd_e(rtE);
    e.fad   = int'(rsD != 0 && regwriteM && writeregM == rsD);
    e.fbd   = int'(rtD != 0 && regwriteM && writeregM == rtD);
    e.stall = int'((lw + br + sb) != 0 && !flush_i);
    e.fe    = int'(e.stall != 0 || flush_i);
    e.fd    = int'(flush_i);
    e.fm    = int'(flush_i);
    e.cnt   = model_count();
    e.sc    = m_stall_cyc;
    e.fc    = m_flush_cnt;
    q.push_back(e);
    @(posedge clk);
    if (resetn) begin
      if (e.stall != 0) m_stall_cyc++;
      if (flush_i) m_flush_cnt++;
      if (flush_i) begin
        for (int i = 0; i < 32; i++) mpend[i] = 1'b0;
      end else begin
        if (cplt_valid && cplt_reg != 0) mpend[cplt_reg] = 1'b0;
        if (longE && regwriteE && writeregE != 0) mpend[writeregE] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic issue_long(input logic [AW-1:0] r);
    clear_inputs();
    longE = 1'b1; regwriteE = 1'b1; writeregE = r;
    step();
  endtask

  // Monitor: outputs are valid every cycle once inputs settle after the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("forwardaE", e.id, int'(forwardaE), e.fae);
        chk("forwardbE", e.id, int'(forwardbE), e.fbe);
        chk("forwardaD", e.id, int'(forwardaD), e.fad);
        chk("forwardbD", e.id, int'(forwardbD), e.fbd);
        chk("stallF", e.id, int'(stallF), e.stall);
        chk("stallD", e.id, int'(stallD), e.stall);
        chk("stallE", e.id, int'(stallE), e.stall);
        chk("flushD", e.id, int'(flushD), e.fd);
        chk("flushE", e.id, int'(flushE), e.fe);
        chk("flushM", e.id, int'(flushM), e.fm);
        chk("pend_cnt", e.id, int'(pend_cnt), e.cnt);
`ifdef HAZARD_PERF_EN
        chk("stall_cyc", e.id, int'(stall_cyc), e.sc);
        chk("flush_cnt", e.id, int'(flush_cnt), e.fc);
`endif
        $display("txn %0d: stall=%0b flushE=%0b fwdaE=%0d fwdbE=%0d pend_cnt=%0d",
                 e.id, stallD, flushE, forwardaE, forwardbE, pend_cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pq[$];
    clear_inputs();
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_pend_cnt", -1, int'(pend_cnt), 0);
    chk("reset_stallD", -1, int'(stallD), 0);
    resetn = 1'b1;

    // 1: forwarding priority M > W, and r0 never forwarded
    clear_inputs();
    regwriteE = 1'b1; writeregE = 8;
    regwriteM = 1'b1; writeregM = 8; regwriteW = 1'b1; writeregW = 8; rsE = 8;
    step();
    regwriteM = 1'b0;
    step();
    rsE = 0;
    step();

    // 2: load-use stall, then forward from M
    clear_inputs();
    memtoregE = 1'b1; regwriteE = 1'b1; writeregE = 5; rtE = 5; rsD = 5;
    step();
    clear_inputs();
    regwriteM = 1'b1; memtoregM = 1'b1; writeregM = 5; rsE = 5;
    step();

    // 3: long op on r9, dependent D op stalls until the cycle after completion
    issue_long(9);
    clear_inputs(); rsD = 9;
    step();
    step();
    cplt_valid = 1'b1; cplt_reg = 9;
    step();
    cplt_valid = 1'b0;
    step();

    // 4: issue and completion of r4 on the same edge keeps r4 pending
    issue_long(4);
    clear_inputs();
    longE = 1'b1; regwriteE = 1'b1; writeregE = 4; cplt_valid = 1'b1; cplt_reg = 4;
    step();
    clear_inputs(); rtD = 4;
    step();
    cplt_valid = 1'b1; cplt_reg = 4;
    step();
    clear_inputs();
    step();

    // 5: flush wipes the scoreboard and drops a same-cycle issue
    issue_long(3);
    issue_long(7);
    clear_inputs();
    rsD = 3; flush_i = 1'b1; longE = 1'b1; regwriteE = 1'b1; writeregE = 10;
    step();
    clear_inputs(); rsD = 10; rtD = 7;
    step();

    // 6: asynchronous reset while r6 is pending
    issue_long(6);
    clear_inputs();
    step();
    resetn = 1'b0;
    #1;
    chk("async_rst_pend_cnt", -1, int'(pend_cnt), 0);
`ifdef HAZARD_PERF_EN
    chk("async_rst_stall_cyc", -1, int'(stall_cyc), 0);
`endif
    for (int i = 0; i < 32; i++) mpend[i] = 1'b0;
    m_stall_cyc = 0;
    m_flush_cnt = 0;
    @(negedge clk);
    resetn = 1'b1;

    // Ten load-use stall cycles for the perf counter
    clear_inputs();
    memtoregE = 1'b1; rtE = 5; rsD = 5;
    for (int i = 0; i < 10; i++) step();
    clear_inputs();
    step();
`ifdef HAZARD_PERF_EN
    chk("stall_cyc_10", -1, int'(stall_cyc), 10);
`endif

    // Randomized traffic over a small register window to provoke collisions
    for (int n = 0; n < 400; n++) begin
      rsD = AW'($urandom_range(0, 7));
      rtD = AW'($urandom_range(0, 7));
      writeregD = AW'($urandom_range(0, 7));
      regwriteD = 1'($urandom_range(0, 1));
      branchD = ($urandom_range(0, 3) == 0);
      rsE = AW'($urandom_range(0, 7));
      rtE = AW'($urandom_range(0, 7));
      writeregE = AW'($urandom_range(0, 7));
      regwriteE = 1'($urandom_range(0, 1));
      memtoregE = ($urandom_range(0, 3) == 0);
      longE = ($urandom_range(0, 3) == 0);
      writeregM = AW'($urandom_range(0, 7));
      regwriteM = 1'($urandom_range(0, 1));
      memtoregM = ($urandom_range(0, 3) == 0);
      writeregW = AW'($urandom_range(0, 7));
      regwriteW = 1'($urandom_range(0, 1));
      flush_i = ($urandom_range(0, 19) == 0);
      pq.delete();
      for (int i = 1; i < 32; i++) if (mpend[i]) pq.push_back(i);
      cplt_valid = 1'b0;
      cplt_reg = '0;
      if (pq.size() != 0 && $urandom_range(0, 2) == 0) begin
        cplt_valid = 1'b1;
        cplt_reg = AW'(pq[$urandom_range(0, pq.size() - 1)]);
      end else if ($urandom_range(0, 19) == 0) begin
        cplt_valid = 1'b1;
      end
      if (longE && regwriteE && writeregE != 0 && !flush_i && mpend[writeregE] &&
          !(cplt_valid && cplt_reg == writeregE))
        longE = 1'b0;
      step();
    end

    clear_inputs();
    step();
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", -1, q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
